// File: rtl/trace_buffer_pkg.sv
// Shared types and helpers for the execution-trace capture buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trace_buffer_pkg;

    // Width of the per-entry cycle stamp.
    localparam int CYCLE_W = 32;

    typedef enum logic {
        CONT = 1'b0,
        TRIG = 1'b1
    } trace_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } trace_state_e;

    // Entry layout: {cycle, ch[NUM_CH-1]..ch[0]}, each ch = {valid, pc, instr}.
    function automatic int trace_entry_w(input int num_ch, input int xlen);
        return CYCLE_W + num_ch * (1 + 2 * xlen);
    endfunction

endpackage

// File: rtl/trace_trigger.sv
// Combinational trigger match on channel 0: external trigger or PC compare.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; qualified by state/mode/enable in the parent.
// Ports: trig_pc_en_i/trig_pc_i/trig_ext_i trigger controls, ch0_valid_i/ch0_pc_i
//        channel 0 tap, match_o raw trigger condition.
module trace_trigger #(
    parameter int XLEN = 32
) (
    input  logic            trig_pc_en_i,
    input  logic [XLEN-1:0] trig_pc_i,
    input  logic            trig_ext_i,
    input  logic            ch0_valid_i,
    input  logic [XLEN-1:0] ch0_pc_i,
    output logic            match_o
);

    assign match_o = trig_ext_i | (trig_pc_en_i & ch0_valid_i & (ch0_pc_i == trig_pc_i));

endmodule

// File: rtl/trace_buffer.sv
// Circular trace capture buffer with continuous / trigger-stop modes and a drain stream.
// Latency: write on the sampling edge; first drain beat valid in the first DRAIN cycle.
// Backpressure: out_data/out_last held while out_valid && !out_ready; 1 beat/cycle otherwise.
// Ports: clk/rst, capture controls (enable, mode, arm, stop, only_valid), stage taps
//        (cycle_count, ch_*), trigger inputs (trig_*), drain stream (out_*), status
//        (state, count, wrapped).
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int NUM_CH    = 1,
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int ENTRY_W   = trace_entry_w(NUM_CH, XLEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     only_valid,
    input  logic [31:0]              cycle_count,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*XLEN-1:0]   ch_pc,
    input  logic [NUM_CH*XLEN-1:0]   ch_instr,
    input  logic                     trig_pc_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     trig_ext,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENTRY_W-1:0]       out_data,
    output logic                     out_last,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = 1 + 2 * XLEN;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    trace_state_e       state_q;
    trace_mode_e        mode_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, rd_left_q, post_left_q;
    logic               wrapped_q;

    logic [ENTRY_W-1:0] wr_entry;
    logic               trig_match, trig_hit, wr_en, beat_acc;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [CNT_W-1:0]   count_d;
    logic               wrapped_d;

    always_comb begin
        wr_entry = '0;
        wr_entry[ENTRY_W-1 -: CYCLE_W] = cycle_count;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_entry[i*CH_W +: CH_W] = {ch_valid[i], ch_pc[i*XLEN +: XLEN], ch_instr[i*XLEN +: XLEN]};
        end
    end

    trace_trigger #(.XLEN(XLEN)) u_trigger (
        .trig_pc_en_i (trig_pc_en),
        .trig_pc_i    (trig_pc),
        .trig_ext_i   (trig_ext),
        .ch0_valid_i  (ch_valid[0]),
        .ch0_pc_i     (ch_pc[XLEN-1:0]),
        .match_o      (trig_match)
    );

    assign trig_hit = enable & (state_q == ARMED) & (mode_q == TRIG) & trig_match;
    // The trigger entry is stored even when only_valid would otherwise drop it.
    assign wr_en    = ((state_q == ARMED) | (state_q == POST)) & enable
                    & (~only_valid | (|ch_valid) | trig_hit);

    // Post-write pointer/count values; DRAIN setup needs them when the final
    // write and the state change share an edge.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == CNT_W'(DEPTH)) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign out_valid = (state_q == DRAIN) && (rd_left_q != '0);
    assign out_last  = out_valid && (rd_left_q == CNT_W'(1));
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign beat_acc  = out_valid & out_ready;
    assign state     = state_q;
    assign count     = count_q;
    assign wrapped   = wrapped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= CONT;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_left_q   <= '0;
            post_left_q <= '0;
            wrapped_q   <= 1'b0;
        end else if (arm) begin
            state_q     <= ARMED;
            mode_q      <= trace_mode_e'(mode);
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            rd_left_q   <= '0;
            post_left_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (trig_hit) begin
                        if (POST_TRIG == 1) begin
                            state_q   <= DRAIN;
                            rd_ptr_q  <= wrapped_d ? wr_ptr_d : '0;
                            rd_left_q <= count_d;
                        end else begin
                            state_q     <= POST;
                            post_left_q <= CNT_W'(POST_TRIG - 1);
                        end
                    end else if ((mode_q == CONT) && stop) begin
                        state_q   <= DRAIN;
                        rd_ptr_q  <= wrapped_d ? wr_ptr_d : '0;
                        rd_left_q <= count_d;
                    end
                end
                POST: begin
                    if (wr_en) begin
                        post_left_q <= post_left_q - 1'b1;
                        if (post_left_q == CNT_W'(1)) begin
                            state_q   <= DRAIN;
                            rd_ptr_q  <= wrapped_d ? wr_ptr_d : '0;
                            rd_left_q <= count_d;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_left_q == '0) begin
                        state_q <= IDLE;
                    end else if (beat_acc) begin
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        rd_left_q <= rd_left_q - 1'b1;
                        if (rd_left_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; wr_en is already low outside ARMED/POST.
    always_ff @(posedge clk) begin
        if (wr_en && !arm) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

On-chip, synthesizable execution-trace capture buffer: the hardware successor to the simulation-only JSONL trace logger. Records per-cycle {cycle stamp, per-channel valid/pc/instr} for NUM_CH pipeline stages into a DEPTH-entry circular buffer. Supports continuous and trigger-stop capture, a PC-match or external trigger, and a valid-only filter. Drains oldest→newest over a valid/ready stream to the debug/UART path; sits beside the core, fed from the same stage taps as the logger.

## Interface
- NUM_CH, 1: number of stage channels (1 for single-stage, 5 for pipelined core).
- XLEN, 32: pc/instr width.
- DEPTH, 16: entries; power of two, ≥4.
- POST_TRIG, 8: entries captured from trigger onward, trigger entry included; 1..DEPTH.
- ENTRY_W, 32+NUM_CH*(1+2*XLEN): derived; not overridden.
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  capture qualifier.
- mode  in  1  trace_mode_e: CONT=0, TRIG=1; sampled only on arm.
- arm  in  1  pulse: clear buffer, start capture.
- stop  in  1  pulse: CONT mode freeze; ignored in TRIG mode.
- only_valid  in  1  write only cycles with |ch_valid.
- cycle_count  in  32  cycle stamp.
- ch_valid  in  NUM_CH  per-channel valid.
- ch_pc, ch_instr  in  NUM_CH×XLEN each  per-channel pc/instr.
- trig_pc_en  in  1  enable PC-match trigger.
- trig_pc  in  XLEN  match value, compared against channel 0.
- trig_ext  in  1  external trigger.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  drain consumer ready.
- out_data  out  ENTRY_W  {cycle, ch[NUM_CH-1]..ch[0]}, each ch = {valid, pc, instr}.
- out_last  out  1  final beat.
- state  out  2  trace_state_e.
- count  out  $clog2(DEPTH)+1  entries held, saturating at DEPTH.
- wrapped  out  1  at least one entry overwritten.

## Operation
- States: IDLE→(arm)→ARMED→(trigger, TRIG mode)→POST→(post_left=0)→DRAIN→(last beat accepted)→IDLE. CONT mode: ARMED→(stop)→DRAIN.
- arm in any state: wr_ptr=0, count=0, wrapped=0, latch mode, go ARMED; aborts POST or DRAIN.
- wr condition: state∈{ARMED,POST} ∧ enable ∧ (!only_valid ∨ |ch_valid ∨ trig_hit). Write mem[wr_ptr], wr_ptr+1 mod DEPTH, count saturates at DEPTH; wrapped set when a write occurs with count==DEPTH.
- trig_hit = enable ∧ state==ARMED ∧ mode==TRIG ∧ (trig_ext ∨ (trig_pc_en ∧ ch_valid[0] ∧ ch_pc[0]==trig_pc)). The trigger-cycle entry is always written; post_left loads POST_TRIG-1. If POST_TRIG==1, go directly to DRAIN.
- POST: each write decrements post_left; the write taking it to 0 moves to DRAIN. enable low pauses capture.
- Triggers in POST/DRAIN/IDLE are ignored; stop is honoured only in ARMED in CONT mode.
- DRAIN: rd_ptr = wrapped ? wr_ptr : 0; rd_left = count. out_valid = (rd_left≠0); out_data = mem[rd_ptr]; out_last = (rd_left==1). Beat accepted on out_valid∧out_ready: rd_ptr+1 mod DEPTH, rd_left−1. With count==0 on entry: out_valid stays 0 and the FSM returns to IDLE the next cycle.
- Buffer contents are frozen in DRAIN and IDLE.

## Timing
- Reset values: state=IDLE, out_valid=0, out_last=0, out_data=0, count=0, wrapped=0, all pointers 0. Memory contents are not reset.
- Write and state change occur on the same edge that samples the trigger, stop, or final post write.
- Storage is a flop array with combinational read: out_valid is high in the first cycle of DRAIN.
- Sustains 1 beat/cycle while out_ready is high. out_data and out_last are held stable while out_valid∧!out_ready.
- arm coincident with trigger or stop: arm wins. arm coincident with the final accepted beat: arm wins, go ARMED.
- Asserting rst mid-operation: immediate return to IDLE; no partial drain resumes.

## Structure
- riscvibe_pkg gains:
  - trace_mode_e {CONT, TRIG}
  - trace_state_e {IDLE, ARMED, POST, DRAIN}
  - function trace_entry_w(NUM_CH, XLEN)
- One sub-module, trace_trigger: combinational trigger match over trig_pc_en/trig_pc/trig_ext/channel 0, kept separate for later multi-comparator extension.
- Top level holds the FSM, pointers, counters, and memory.

## Test plan
All scenarios use NUM_CH=2, DEPTH=8, POST_TRIG=3.
- CONT mode: arm, 5 enabled cycles at cycle_count 10..14, stop. Required: 5 beats with cycle stamps 10..14, out_last on the 5th, wrapped=0, then IDLE.
- CONT mode: arm, 12 enabled cycles (cycle_count 0..11), stop. Required: count=8, wrapped=1, beats carry stamps 4..11 in order.
- TRIG mode: trig_pc=0x100; channel 0 reaches pc 0x100 at cycle_count 20 after 10 prior cycles. Required: DRAIN after cycle 22; 8 beats with stamps 15..22, the trigger entry at beat 6.
- TRIG mode with only_valid=1 and ch_valid=0 on alternate cycles: required only valid cycles stored. trig_ext pulsed on an invalid cycle: that entry is still stored.
- DRAIN backpressure: out_ready toggled 1,0,0,1. Required: out_data stable while stalled, no beat lost or duplicated. arm asserted mid-drain: required ARMED, count=0.
- rst asserted during POST: required state=IDLE and out_valid=0 immediately. A following arm with no captured entries and stop leads to DRAIN with count=0, no beats, then IDLE.
